// File: rtl/data_bus_responder.sv
// ----------------------------------------------------------------------------
// data_bus_responder
//
// Data-side bus terminator for the single-cycle RISC-V core. Every load/store
// the core issues is decoded here into either the word-organised data RAM or a
// 16-byte MMIO window. Reads are purely combinational and return the aligned
// little-endian word. Stores commit on the rising clock edge.
//
// MMIO window (offset from MMIO_BASE):
//   0x0 GPIO       RW, bits [7:0] drive o_gpio
//   0x4 CYCLE      RO, free-running edge counter
//   0x8 ERR_STATUS W1C, bit0 MISALIGN, bit1 UNMAPPED, bit2 BADLEN
//   0xC ERR_ADDR   RO, address of the first error since status was all-zero
//
// Ports:
//   i_clk               clock, all state updates on the rising edge
//   i_reset_n           asynchronous active-low reset
//   i_bus_address       byte address from the core
//   i_bus_wr_data       right-justified store data
//   i_bus_write_length  store size: 1 byte, 2 half, 4 word
//   i_bus_wr_enable     store request for the current cycle
//   o_bus_read_data     combinational read of the aligned word
//   o_gpio              GPIO output register
//   o_err               OR of the ERR_STATUS bits
//   o_err_addr          captured error address
// ----------------------------------------------------------------------------
module data_bus_responder #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_bus_address,
  input  logic [31:0] i_bus_wr_data,
  input  logic [2:0]  i_bus_write_length,
  input  logic        i_bus_wr_enable,
  output logic [31:0] o_bus_read_data,
  output logic [7:0]  o_gpio,
  output logic        o_err,
  output logic [31:0] o_err_addr
);

  localparam int unsigned IDX_W     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

  localparam logic [1:0] OFF_GPIO       = 2'd0;
  localparam logic [1:0] OFF_CYCLE      = 2'd1;
  localparam logic [1:0] OFF_ERR_STATUS = 2'd2;
  localparam logic [1:0] OFF_ERR_ADDR   = 2'd3;

  localparam logic [2:0] ERR_MISALIGN = 3'b001;
  localparam logic [2:0] ERR_UNMAPPED = 3'b010;
  localparam logic [2:0] ERR_BADLEN   = 3'b100;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] ram_q [RAM_WORDS];

  // run_q stays low through reset and for the first edge after release, so a
  // store held across release (even one racing the releasing edge) is dropped.
  logic        run_q,        run_d;
  logic [7:0]  gpio_q,       gpio_d;
  logic [31:0] cycle_q,      cycle_d;
  logic [2:0]  err_status_q, err_status_d;
  logic [31:0] err_addr_q,   err_addr_d;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic             ram_hit;
  logic             mmio_hit;
  logic [1:0]       mmio_off;
  logic [IDX_W-1:0] ram_idx;

  assign ram_hit  = ({1'b0, i_bus_address} < RAM_BYTES);
  // RAM wins if a misconfigured MMIO_BASE ever overlaps it.
  assign mmio_hit = (i_bus_address[31:4] == MMIO_BASE[31:4]) && !ram_hit;
  assign mmio_off = i_bus_address[3:2];
  assign ram_idx  = i_bus_address[IDX_W+1:2];

  logic len_byte;
  logic len_half;
  logic len_word;
  logic len_legal;

  assign len_byte  = (i_bus_write_length == 3'd1);
  assign len_half  = (i_bus_write_length == 3'd2);
  assign len_word  = (i_bus_write_length == 3'd4);
  assign len_legal = len_byte || len_half || len_word;

  // --------------------------------------------------------------------------
  // Error classification (only the highest-priority cause is reported)
  // --------------------------------------------------------------------------
  logic [2:0] err_cause;

  always_comb begin
    err_cause = 3'b000;
    if (!len_legal || (mmio_hit && !len_word)) begin
      err_cause = ERR_BADLEN;
    end else if ((len_half && i_bus_address[0]) ||
                 (len_word && (i_bus_address[1:0] != 2'b00))) begin
      err_cause = ERR_MISALIGN;
    end else if (!ram_hit && !mmio_hit) begin
      err_cause = ERR_UNMAPPED;
    end
  end

  logic wr_act;
  logic wr_fault;
  logic wr_commit;
  logic ram_wr;
  logic mmio_wr;

  assign wr_act    = i_bus_wr_enable && run_q;
  assign wr_fault  = wr_act && (err_cause != 3'b000);
  assign wr_commit = wr_act && (err_cause == 3'b000);
  assign ram_wr    = wr_commit && ram_hit;
  assign mmio_wr   = wr_commit && mmio_hit;

  // --------------------------------------------------------------------------
  // RAM lane steering: data is replicated across lanes so each enabled lane
  // picks its byte from the same bit position it occupies in the word.
  // --------------------------------------------------------------------------
  logic [3:0]  lane_be;
  logic [31:0] lane_data;

  always_comb begin
    lane_be   = 4'b0000;
    lane_data = i_bus_wr_data;
    if (len_byte) begin
      lane_be   = 4'b0001 << i_bus_address[1:0];
      lane_data = {4{i_bus_wr_data[7:0]}};
    end else if (len_half) begin
      lane_be   = i_bus_address[1] ? 4'b1100 : 4'b0011;
      lane_data = {2{i_bus_wr_data[15:0]}};
    end else if (len_word) begin
      lane_be   = 4'b1111;
      lane_data = i_bus_wr_data;
    end
  end

  // RAM has no reset; contents are undefined until written.
  always_ff @(posedge i_clk) begin
    if (ram_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_be[k]) begin
          ram_q[ram_idx][8*k +: 8] <= lane_data[8*k +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // MMIO register next-state
  // --------------------------------------------------------------------------
  logic [2:0] err_clr;
  logic [2:0] err_set;

  always_comb begin
    run_d   = 1'b1;
    cycle_d = cycle_q + 32'd1;

    gpio_d = gpio_q;
    if (mmio_wr && (mmio_off == OFF_GPIO)) begin
      gpio_d = i_bus_wr_data[7:0];
    end

    err_clr = 3'b000;
    if (mmio_wr && (mmio_off == OFF_ERR_STATUS)) begin
      err_clr = i_bus_wr_data[2:0];
    end
    err_set = wr_fault ? err_cause : 3'b000;

    // Set is applied after clear so a fresh error beats a same-edge W1C.
    err_status_d = (err_status_q & ~err_clr) | err_set;

    err_addr_d = err_addr_q;
    if (wr_fault && (err_status_q == 3'b000)) begin
      err_addr_d = i_bus_address;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      run_q        <= 1'b0;
      gpio_q       <= 8'h00;
      cycle_q      <= 32'h0;
      err_status_q <= 3'b000;
      err_addr_q   <= 32'h0;
    end else begin
      run_q        <= run_d;
      gpio_q       <= gpio_d;
      cycle_q      <= cycle_d;
      err_status_q <= err_status_d;
      err_addr_q   <= err_addr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  always_comb begin
    o_bus_read_data = 32'h0;
    if (ram_hit) begin
      o_bus_read_data = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_off)
        OFF_GPIO:       o_bus_read_data = {24'h0, gpio_q};
        OFF_CYCLE:      o_bus_read_data = cycle_q;
        OFF_ERR_STATUS: o_bus_read_data = {29'h0, err_status_q};
        OFF_ERR_ADDR:   o_bus_read_data = err_addr_q;
        default:        o_bus_read_data = 32'h0;
      endcase
    end
  end

  assign o_gpio     = gpio_q;
  assign o_err      = |err_status_q;
  assign o_err_addr = err_addr_q;

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;

  localparam int unsigned RAM_WORDS = 1024;
  localparam bit [31:0]   MMIO_BASE = 32'h8000_0000;
  localparam bit [31:0]   RAM_BYTES = 32'(RAM_WORDS * 4);

  logic        i_clk;
  logic        i_reset_n;
  logic [31:0] i_bus_address;
  logic [31:0] i_bus_wr_data;
  logic [2:0]  i_bus_write_length;
  logic        i_bus_wr_enable;
  logic [31:0] o_bus_read_data;
  logic [7:0]  o_gpio;
  logic        o_err;
  logic [31:0] o_err_addr;

  data_bus_responder #(
    .RAM_WORDS(RAM_WORDS),
    .MMIO_BASE(MMIO_BASE)
  ) dut (
    .i_clk             (i_clk),
    .i_reset_n         (i_reset_n),
    .i_bus_address     (i_bus_address),
    .i_bus_wr_data     (i_bus_wr_data),
    .i_bus_write_length(i_bus_write_length),
    .i_bus_wr_enable   (i_bus_wr_enable),
    .o_bus_read_data   (o_bus_read_data),
    .o_gpio            (o_gpio),
    .o_err             (o_err),
    .o_err_addr        (o_err_addr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: byte-addressed memory plus plain register values.
  bit [7:0]  m_mem [bit [31:0]];
  bit [7:0]  m_gpio;
  bit [31:0] m_cyc;
  bit [2:0]  m_status;
  bit [31:0] m_err_addr;
  bit        m_run;

  int n_pass;
  int n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, want);
  endtask

  function automatic bit model_read(input bit [31:0] a, output bit [31:0] v);
    bit [31:0] base;
    v = 32'h0;
    if (a < RAM_BYTES) begin
      base = a & ~32'h3;
      for (int i = 0; i < 4; i++) begin
        if (!m_mem.exists(base + 32'(i))) return 1'b0;
        v[8*i +: 8] = m_mem[base + 32'(i)];
      end
      return 1'b1;
    end
    if (a[31:4] == MMIO_BASE[31:4]) begin
      case ((a - MMIO_BASE) / 4)
        0: v = {24'h0, m_gpio};
        1: v = m_cyc;
        2: v = {29'h0, m_status};
        default: v = m_err_addr;
      endcase
    end
    return 1'b1;
  endfunction

  task automatic model_store(input bit [31:0] a, input bit [31:0] d, input bit [2:0] len);
    bit [2:0] eb;
    bit legal, in_ram, in_mmio;
    legal   = (len == 3'd1) || (len == 3'd2) || (len == 3'd4);
    in_ram  = a < RAM_BYTES;
    in_mmio = !in_ram && (a[31:4] == MMIO_BASE[31:4]);
    if (!legal || (in_mmio && len != 3'd4)) eb = 3'd4;
    else if ((a % 32'(len)) != 0)            eb = 3'd1;
    else if (!in_ram && !in_mmio)            eb = 3'd2;
    else                                     eb = 3'd0;
    if (eb != 3'd0) begin
      if (m_status == 3'd0) m_err_addr = a;
      m_status = m_status | eb;
    end else if (in_ram) begin
      for (int i = 0; i < int'(len); i++) m_mem[a + 32'(i)] = d[8*i +: 8];
    end else begin
      case ((a - MMIO_BASE) / 4)
        0: m_gpio = d[7:0];
        2: m_status = m_status & ~d[2:0];
        default: ;
      endcase
    end
  endtask

  task automatic model_edge(input bit [31:0] a, input bit [31:0] d, input bit [2:0] len, input bit we);
    if (m_run && we) model_store(a, d, len);
    m_cyc = m_cyc + 32'd1;
    m_run = 1'b1;
  endtask

  task automatic model_reset();
    m_gpio = 8'h0; m_cyc = 32'h0; m_status = 3'h0; m_err_addr = 32'h0; m_run = 1'b0;
  endtask

  // One bus cycle, started right after a falling edge.
  task automatic cyc(input bit [31:0] a, input bit [31:0] d, input bit [2:0] len, input bit we);
    bit [31:0] v;
    i_bus_address = a; i_bus_wr_data = d; i_bus_write_length = len; i_bus_wr_enable = we;
    #1;
    if (model_read(a, v)) chk("read", o_bus_read_data, v);
    @(posedge i_clk);
    model_edge(a, d, len, we);
    @(negedge i_clk);
    i_bus_wr_enable = 1'b0;
    chk("gpio", {24'h0, o_gpio}, {24'h0, m_gpio});
    chk("err", {31'h0, o_err}, {31'h0, |m_status});
    chk("err_addr", o_err_addr, m_err_addr);
  endtask

  // Idle cycle with a directed read check against a fixed value.
  task automatic peek(input bit [31:0] a, input string tag, input bit [31:0] want);
    i_bus_address = a; i_bus_wr_enable = 1'b0; i_bus_write_length = 3'd4;
    #1;
    chk(tag, o_bus_read_data, want);
    @(posedge i_clk);
    model_edge(a, 32'h0, 3'd4, 1'b0);
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  bit [2:0]  lens [7] = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd4, 3'd3, 3'd0};
  bit [31:0] ra, rd;
  int        sel;

  initial begin
    n_pass = 0; n_total = 0;
    i_reset_n = 1'b0;
    i_bus_address = 32'h0; i_bus_wr_data = 32'h0; i_bus_write_length = 3'd4; i_bus_wr_enable = 1'b0;
    model_reset();
    repeat (3) @(negedge i_clk);
    i_bus_address = MMIO_BASE + 32'h4;
    #1;
    chk("rst_gpio", {24'h0, o_gpio}, 32'h0);
    chk("rst_err", {31'h0, o_err}, 32'h0);
    chk("rst_err_addr", o_err_addr, 32'h0);
    chk("rst_cycle", o_bus_read_data, 32'h0);
    #1 i_reset_n = 1'b1;

    // Free-running counter: 10 edges after release.
    for (int i = 0; i < 10; i++) cyc(MMIO_BASE + 32'h4, 32'h0, 3'd4, 1'b0);
    peek(MMIO_BASE + 32'h4, "cycle10", 32'd10);

    // Word then byte merge.
    cyc(32'h10, 32'h1234_5678, 3'd4, 1'b1);
    cyc(32'h11, 32'h0000_00AB, 3'd1, 1'b1);
    peek(32'h10, "byte_merge", 32'h1234_AB78);
    cyc(32'h100, 32'hDEAD_BEEF, 3'd4, 1'b1);

    // Half store, then misaligned half.
    cyc(32'h20, 32'h0000_1111, 3'd4, 1'b1);
    cyc(32'h22, 32'h0000_BEEF, 3'd2, 1'b1);
    peek(32'h20, "half_upper", 32'hBEEF_1111);
    cyc(32'h21, 32'h0000_CAFE, 3'd2, 1'b1);
    peek(MMIO_BASE + 32'h8, "misalign_status", 32'h1);
    peek(MMIO_BASE + 32'hC, "misalign_addr", 32'h21);
    peek(32'h20, "misalign_ram_kept", 32'hBEEF_1111);
    cyc(MMIO_BASE + 32'h8, 32'h7, 3'd4, 1'b1);

    // GPIO word write and sub-word MMIO write.
    cyc(MMIO_BASE, 32'h0000_01FF, 3'd4, 1'b1);
    chk("gpio_ff", {24'h0, o_gpio}, 32'hFF);
    peek(MMIO_BASE, "gpio_read", 32'h0000_00FF);
    cyc(MMIO_BASE, 32'h0000_0012, 3'd1, 1'b1);
    peek(MMIO_BASE + 32'h8, "badlen_mmio", 32'h4);
    peek(MMIO_BASE, "gpio_hold", 32'h0000_00FF);
    cyc(MMIO_BASE + 32'h8, 32'h7, 3'd4, 1'b1);

    // Error priority, address capture and W1C interplay.
    cyc(32'h8, 32'h0, 3'd3, 1'b1);
    peek(MMIO_BASE + 32'h8, "badlen_len3", 32'h4);
    cyc(32'h4000_0000, 32'h55, 3'd4, 1'b1);
    peek(MMIO_BASE + 32'h8, "status6", 32'h6);
    chk("err_addr_first", o_err_addr, 32'h8);
    cyc(MMIO_BASE + 32'h8, 32'h4, 3'd1, 1'b1);
    peek(MMIO_BASE + 32'h8, "bit2_stays", 32'h6);
    cyc(MMIO_BASE + 32'h8, 32'h2, 3'd4, 1'b1);
    peek(MMIO_BASE + 32'h8, "w1c_bit1", 32'h4);
    chk("err_addr_after_w1c", o_err_addr, 32'h8);
    cyc(MMIO_BASE + 32'h8, 32'h7, 3'd4, 1'b1);
    cyc(32'h0000_1000, 32'h0, 3'd4, 1'b1);
    peek(MMIO_BASE + 32'hC, "err_addr_recapture", 32'h0000_1000);
    cyc(MMIO_BASE + 32'h8, 32'h7, 3'd4, 1'b1);

    // Counter wrap via preload.
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1 release dut.cycle_q;
    m_cyc = 32'hFFFF_FFFF;
    peek(MMIO_BASE + 32'h4, "cycle_preload", 32'hFFFF_FFFF);
    peek(MMIO_BASE + 32'h4, "cycle_wrap", 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      ra = $urandom_range(0, 63);
      else if (sel <= 7) ra = MMIO_BASE + $urandom_range(0, 15);
      else if (sel == 8) ra = 32'h4000_0000 + $urandom_range(0, 255);
      else               ra = RAM_BYTES - 32'h4 + $urandom_range(0, 7);
      rd = $urandom;
      if (i % 16 == 15) cyc(MMIO_BASE + 32'h8, 32'h7, 3'd4, 1'b1);
      else cyc(ra, rd, lens[$urandom_range(0, 6)], ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset during a GPIO store, store held across release.
    cyc(MMIO_BASE, 32'hC3, 3'd4, 1'b1);
    cyc(32'h4000_0000, 32'h0, 3'd4, 1'b1);
    i_bus_address = MMIO_BASE; i_bus_wr_data = 32'h5A; i_bus_write_length = 3'd4; i_bus_wr_enable = 1'b1;
    #2 i_reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_gpio", {24'h0, o_gpio}, 32'h0);
    chk("async_err", {31'h0, o_err}, 32'h0);
    chk("async_err_addr", o_err_addr, 32'h0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk);
    model_edge(MMIO_BASE, 32'h5A, 3'd4, 1'b1);
    @(negedge i_clk);
    i_bus_wr_enable = 1'b0;
    chk("held_store_dropped", {24'h0, o_gpio}, 32'h0);
    peek(32'h100, "ram_survives_reset", 32'hDEAD_BEEF);
    peek(MMIO_BASE + 32'h4, "cycle_after_reset", 32'd2);
    cyc(MMIO_BASE, 32'h3C, 3'd4, 1'b1);
    peek(MMIO_BASE, "gpio_after_reset", 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
